// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead byte buffer sitting between the UART receiver and
// the host. Accepts bytes over a valid/ready handshake, exposes the head byte
// with zero latency, and raises a fill-level interrupt, a 16550-style
// character-timeout interrupt and a sticky overrun flag.
module uart_rx_fifo #(
  parameter int DEPTH          = 16,
  parameter int THRESHOLD      = 8,
  parameter int TIMEOUT_CYCLES = 640
) (
  input  logic                     clk,
  input  logic                     rst,
  // Receiver side
  input  logic [7:0]               rx_data,
  input  logic                     rx_data_valid,
  input  logic                     rx_overrun,
  input  logic                     rx_framing_err,
  output logic                     host_ready,
  output logic                     clear_framing_err,
  // Host side
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  input  logic                     rd_en,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     level_irq,
  output logic                     timeout_irq,
  output logic                     overrun_sticky,
  output logic                     framing_err,
  input  logic                     clear_status
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
  localparam logic [CW-1:0] C_THRESH  = CW'(THRESHOLD);
  localparam logic [TW-1:0] C_TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_COUNTING  = 2'd1,
    ST_TIMED_OUT = 2'd2
  } to_state_t;

  // Storage and pointers
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overrun;

  // Timeout FSM
  to_state_t     r_state;
  logic [TW-1:0] r_to_cnt;

  // Combinational helpers
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_activity;
  logic [CW-1:0] w_count_next;
  to_state_t     w_state_next;
  logic [TW-1:0] w_to_cnt_next;

  // Status flags come only from the registered count, so host_ready never
  // depends combinationally on rd_en.
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == C_DEPTH);
  assign w_push     = rx_data_valid & ~w_full;
  assign w_pop      = rd_en & ~w_empty;
  assign w_activity = w_push | w_pop;

  // Occupancy after this edge: push and pop together leave it unchanged.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
    w_count_next = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Pointer and occupancy bookkeeping; reset discards all stored bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state is assigned with <= so every flop samples pre-edge values regardless of statement order.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
    end
  end

  // Byte storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; stale contents are unreachable because reads are gated by the count.
    if (w_push) r_mem[r_wr_ptr] <= rx_data;
  end

  // Sticky overrun: a live overrun beats a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (rx_overrun) begin
      r_overrun <= 1'b1;
    end else if (clear_status) begin
      r_overrun <= 1'b0;
    end
  end

  // Timeout FSM state register, together with its idle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_EMPTY;
      r_to_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_to_cnt <= w_to_cnt_next;
    end
  end

  // Timeout FSM next state: any push or pop restarts the idle count, and the
  // counter parks at its last value once the timeout has fired.
  always_comb begin
    w_state_next  = r_state;
    w_to_cnt_next = r_to_cnt;
    unique case (r_state)
      ST_EMPTY: begin
        w_to_cnt_next = '0;
        if (w_count_next != '0) w_state_next = ST_COUNTING;
      end
      ST_COUNTING: begin
        if (w_activity) begin
          w_to_cnt_next = '0;
          w_state_next  = (w_count_next == '0) ? ST_EMPTY : ST_COUNTING;
        end else if (r_to_cnt == C_TO_LAST) begin
          w_state_next  = ST_TIMED_OUT;
        end else begin
          w_to_cnt_next = r_to_cnt + TW'(1);
        end
      end
      ST_TIMED_OUT: begin
        if (w_activity) begin
          w_to_cnt_next = '0;
          w_state_next  = (w_count_next == '0) ? ST_EMPTY : ST_COUNTING;
        end
      end
      default: begin
        w_to_cnt_next = '0;
        w_state_next  = ST_EMPTY;
      end
    endcase
  end

  // Timeout FSM output decode; driven purely by the state register.
  always_comb begin
    timeout_irq = (r_state == ST_TIMED_OUT);
  end

  // Host-facing outputs.
  assign rd_data           = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign rd_valid          = ~w_empty;
  assign count             = r_count;
  assign full              = w_full;
  assign empty             = w_empty;
  assign host_ready        = ~w_full;
  assign level_irq         = (r_count >= C_THRESH);
  assign overrun_sticky    = r_overrun;
  assign framing_err       = rx_framing_err;
  assign clear_framing_err = clear_status;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a byte queue models the FIFO
// contents; its size is the expected occupancy.
module tb_uart_rx_fifo;

  localparam int DEPTH          = 16;
  localparam int THRESHOLD      = 8;
  localparam int TIMEOUT_CYCLES = 640;
  localparam int CW             = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_data_valid;
  logic          rx_overrun;
  logic          rx_framing_err;
  logic          host_ready;
  logic          clear_framing_err;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_en;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          level_irq;
  logic          timeout_irq;
  logic          overrun_sticky;
  logic          framing_err;
  logic          clear_status;

  int n_vectors     = 0;
  int n_miscompares = 0;
  logic [7:0] sb[$];

  uart_rx_fifo #(
    .DEPTH          (DEPTH),
    .THRESHOLD      (THRESHOLD),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_data           (rx_data),
    .rx_data_valid     (rx_data_valid),
    .rx_overrun        (rx_overrun),
    .rx_framing_err    (rx_framing_err),
    .host_ready        (host_ready),
    .clear_framing_err (clear_framing_err),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .rd_en             (rd_en),
    .count             (count),
    .full              (full),
    .empty             (empty),
    .level_irq         (level_irq),
    .timeout_irq       (timeout_irq),
    .overrun_sticky    (overrun_sticky),
    .framing_err       (framing_err),
    .clear_status      (clear_status)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte for a single cycle; the model records it only if there was room.
  task automatic push_one(input logic [7:0] b);
    rx_data       = b;
    rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
    if (sb.size() < DEPTH) sb.push_back(b);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vectors++; if (empty !== 1'b1)       begin n_miscompares++; $display("FAIL reset_empty: got %b exp 1", empty); end
    n_vectors++; if (full !== 1'b0)        begin n_miscompares++; $display("FAIL reset_full: got %b exp 0", full); end
    n_vectors++; if (rd_valid !== 1'b0)    begin n_miscompares++; $display("FAIL reset_rd_valid: got %b exp 0", rd_valid); end
    n_vectors++; if (rd_data !== 8'h00)    begin n_miscompares++; $display("FAIL reset_rd_data: got %h exp 00", rd_data); end
    n_vectors++; if (host_ready !== 1'b1)  begin n_miscompares++; $display("FAIL reset_host_ready: got %b exp 1", host_ready); end
    n_vectors++; if (count !== '0)         begin n_miscompares++; $display("FAIL reset_count: got %0d exp 0", count); end
    n_vectors++; if (level_irq !== 1'b0)   begin n_miscompares++; $display("FAIL reset_level_irq: got %b exp 0", level_irq); end
    n_vectors++; if (timeout_irq !== 1'b0) begin n_miscompares++; $display("FAIL reset_timeout_irq: got %b exp 0", timeout_irq); end
    n_vectors++; if (overrun_sticky !== 1'b0) begin n_miscompares++; $display("FAIL reset_overrun: got %b exp 0", overrun_sticky); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    push_one(8'hA5);
    push_one(8'h3C);
    n_vectors++; if (count !== CW'(sb.size())) begin n_miscompares++; $display("FAIL basic_count2: got %0d exp %0d", count, sb.size()); end
    n_vectors++; if (rd_valid !== 1'b1)        begin n_miscompares++; $display("FAIL basic_rd_valid: got %b exp 1", rd_valid); end
    n_vectors++; if (rd_data !== sb[0])        begin n_miscompares++; $display("FAIL basic_head_a5: got %h exp %h", rd_data, sb[0]); end
    pop_one();
    n_vectors++; if (rd_data !== sb[0])        begin n_miscompares++; $display("FAIL basic_head_3c: got %h exp %h", rd_data, sb[0]); end
    n_vectors++; if (count !== CW'(sb.size())) begin n_miscompares++; $display("FAIL basic_count1: got %0d exp %0d", count, sb.size()); end
    pop_one();
    n_vectors++; if (empty !== 1'b1)           begin n_miscompares++; $display("FAIL basic_empty: got %b exp 1", empty); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      rx_data       = 8'(i);
      rx_data_valid = 1'b1;
      n_vectors++; if (host_ready !== 1'b1) begin n_miscompares++; $display("FAIL fill_ready_%0d: got %b exp 1", i, host_ready); end
      tick();
      sb.push_back(8'(i));
      n_vectors++;
      if (level_irq !== (sb.size() >= THRESHOLD)) begin
        n_miscompares++; $display("FAIL fill_level_irq_%0d: got %b exp %b", i, level_irq, sb.size() >= THRESHOLD);
      end
    end
    n_vectors++; if (full !== 1'b1) begin n_miscompares++; $display("FAIL fill_full: got %b exp 1", full); end
    // Full with a pop pending: the offered byte must still be refused.
    rx_data = 8'hEE;
    rd_en   = 1'b1;
    #1;
    n_vectors++; if (host_ready !== 1'b0) begin n_miscompares++; $display("FAIL full_host_ready: got %b exp 0", host_ready); end
    n_vectors++; if (rd_data !== sb[0])   begin n_miscompares++; $display("FAIL full_head: got %h exp %h", rd_data, sb[0]); end
    tick();
    void'(sb.pop_front());
    rx_data_valid = 1'b0;
    rd_en         = 1'b0;
    n_vectors++; if (count !== CW'(sb.size())) begin n_miscompares++; $display("FAIL full_pop_count: got %0d exp %0d", count, sb.size()); end
    n_vectors++; if (full !== 1'b0)            begin n_miscompares++; $display("FAIL full_pop_full: got %b exp 0", full); end
    for (int i = 0; i < DEPTH && sb.size() > 0; i++) begin
      n_vectors++; if (rd_data !== sb[0]) begin n_miscompares++; $display("FAIL drain_%0d: got %h exp %h", i, rd_data, sb[0]); end
      pop_one();
    end
    n_vectors++; if (empty !== 1'b1)   begin n_miscompares++; $display("FAIL drain_empty: got %b exp 1", empty); end
    n_vectors++; if (rd_data !== 8'h00) begin n_miscompares++; $display("FAIL drain_rd_data: got %h exp 00", rd_data); end
    pop_one();
    n_vectors++; if (count !== '0)     begin n_miscompares++; $display("FAIL pop_empty_count: got %0d exp 0", count); end
    n_vectors++; if (empty !== 1'b1)   begin n_miscompares++; $display("FAIL pop_empty_empty: got %b exp 1", empty); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) push_one(8'(8'h40 + i));
    for (int i = 0; i < 20; i++) begin
      rx_data       = 8'(8'h80 + i);
      rx_data_valid = 1'b1;
      rd_en         = 1'b1;
      n_vectors++; if (rd_data !== sb[0]) begin n_miscompares++; $display("FAIL b2b_head_%0d: got %h exp %h", i, rd_data, sb[0]); end
      tick();
      void'(sb.pop_front());
      sb.push_back(8'(8'h80 + i));
      n_vectors++; if (count !== CW'(5)) begin n_miscompares++; $display("FAIL b2b_count_%0d: got %0d exp 5", i, count); end
    end
    rx_data_valid = 1'b0;
    rd_en         = 1'b0;
    for (int i = 0; i < 5 && sb.size() > 0; i++) begin
      n_vectors++; if (rd_data !== sb[0]) begin n_miscompares++; $display("FAIL b2b_drain_%0d: got %h exp %h", i, rd_data, sb[0]); end
      pop_one();
    end
    n_vectors++; if (empty !== 1'b1) begin n_miscompares++; $display("FAIL b2b_empty: got %b exp 1", empty); end
  endtask

  task automatic test_timeout();
    int rise;
    push_one(8'h11);
    repeat (300) tick();
    n_vectors++; if (timeout_irq !== 1'b0) begin n_miscompares++; $display("FAIL to_early: got %b exp 0", timeout_irq); end
    // A second push restarts the idle count.
    push_one(8'h22);
    rise = -1;
    for (int k = 1; k <= TIMEOUT_CYCLES + 60 && rise < 0; k++) begin
      tick();
      if (timeout_irq === 1'b1) rise = k;
    end
    n_vectors++; if (rise != TIMEOUT_CYCLES) begin n_miscompares++; $display("FAIL to_rise_push: got %0d exp %0d", rise, TIMEOUT_CYCLES); end
    n_vectors++; if (rd_data !== sb[0]) begin n_miscompares++; $display("FAIL to_head: got %h exp %h", rd_data, sb[0]); end
    pop_one();
    n_vectors++; if (timeout_irq !== 1'b0) begin n_miscompares++; $display("FAIL to_clear_pop: got %b exp 0", timeout_irq); end
    rise = -1;
    for (int k = 1; k <= TIMEOUT_CYCLES + 60 && rise < 0; k++) begin
      tick();
      if (timeout_irq === 1'b1) rise = k;
    end
    n_vectors++; if (rise != TIMEOUT_CYCLES) begin n_miscompares++; $display("FAIL to_rise_pop: got %0d exp %0d", rise, TIMEOUT_CYCLES); end
    pop_one();
    n_vectors++; if (timeout_irq !== 1'b0) begin n_miscompares++; $display("FAIL to_clear_last: got %b exp 0", timeout_irq); end
    n_vectors++; if (empty !== 1'b1)       begin n_miscompares++; $display("FAIL to_empty: got %b exp 1", empty); end
    repeat (TIMEOUT_CYCLES + 60) tick();
    n_vectors++; if (timeout_irq !== 1'b0) begin n_miscompares++; $display("FAIL to_idle_empty: got %b exp 0", timeout_irq); end
  endtask

  task automatic test_overrun();
    rx_overrun = 1'b1;
    tick();
    rx_overrun = 1'b0;
    n_vectors++; if (overrun_sticky !== 1'b1) begin n_miscompares++; $display("FAIL ovr_set: got %b exp 1", overrun_sticky); end
    repeat (3) tick();
    n_vectors++; if (overrun_sticky !== 1'b1) begin n_miscompares++; $display("FAIL ovr_hold: got %b exp 1", overrun_sticky); end
    rx_overrun   = 1'b1;
    clear_status = 1'b1;
    #1;
    n_vectors++; if (clear_framing_err !== 1'b1) begin n_miscompares++; $display("FAIL cfe_high: got %b exp 1", clear_framing_err); end
    tick();
    rx_overrun = 1'b0;
    n_vectors++; if (overrun_sticky !== 1'b1) begin n_miscompares++; $display("FAIL ovr_set_wins: got %b exp 1", overrun_sticky); end
    tick();
    clear_status = 1'b0;
    n_vectors++; if (overrun_sticky !== 1'b0) begin n_miscompares++; $display("FAIL ovr_clear: got %b exp 0", overrun_sticky); end
    n_vectors++; if (clear_framing_err !== 1'b0) begin n_miscompares++; $display("FAIL cfe_low: got %b exp 0", clear_framing_err); end
    rx_framing_err = 1'b1;
    #1;
    n_vectors++; if (framing_err !== 1'b1) begin n_miscompares++; $display("FAIL fe_high: got %b exp 1", framing_err); end
    rx_framing_err = 1'b0;
    #1;
    n_vectors++; if (framing_err !== 1'b0) begin n_miscompares++; $display("FAIL fe_low: got %b exp 0", framing_err); end
    tick();
  endtask

  task automatic test_async_reset();
    int waited;
    for (int i = 0; i < 9; i++) push_one(8'(8'h90 + i));
    waited = 0;
    while (timeout_irq !== 1'b1 && waited < TIMEOUT_CYCLES + 60) begin
      tick();
      waited++;
    end
    n_vectors++; if (timeout_irq !== 1'b1)      begin n_miscompares++; $display("FAIL ar_pre_timeout: got %b exp 1", timeout_irq); end
    n_vectors++; if (count !== CW'(sb.size()))  begin n_miscompares++; $display("FAIL ar_pre_count: got %0d exp %0d", count, sb.size()); end
    n_vectors++; if (level_irq !== 1'b1)        begin n_miscompares++; $display("FAIL ar_pre_level: got %b exp 1", level_irq); end
    // Assert reset between clock edges; outputs must respond without an edge.
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    n_vectors++; if (count !== '0)         begin n_miscompares++; $display("FAIL ar_count: got %0d exp 0", count); end
    n_vectors++; if (empty !== 1'b1)       begin n_miscompares++; $display("FAIL ar_empty: got %b exp 1", empty); end
    n_vectors++; if (full !== 1'b0)        begin n_miscompares++; $display("FAIL ar_full: got %b exp 0", full); end
    n_vectors++; if (rd_valid !== 1'b0)    begin n_miscompares++; $display("FAIL ar_rd_valid: got %b exp 0", rd_valid); end
    n_vectors++; if (rd_data !== 8'h00)    begin n_miscompares++; $display("FAIL ar_rd_data: got %h exp 00", rd_data); end
    n_vectors++; if (host_ready !== 1'b1)  begin n_miscompares++; $display("FAIL ar_host_ready: got %b exp 1", host_ready); end
    n_vectors++; if (level_irq !== 1'b0)   begin n_miscompares++; $display("FAIL ar_level: got %b exp 0", level_irq); end
    n_vectors++; if (timeout_irq !== 1'b0) begin n_miscompares++; $display("FAIL ar_timeout: got %b exp 0", timeout_irq); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    push_one(8'h5A);
    n_vectors++; if (rd_data !== 8'h5A)    begin n_miscompares++; $display("FAIL ar_first_push: got %h exp 5a", rd_data); end
    n_vectors++; if (count !== CW'(sb.size())) begin n_miscompares++; $display("FAIL ar_post_count: got %0d exp %0d", count, sb.size()); end
    pop_one();
    n_vectors++; if (empty !== 1'b1)       begin n_miscompares++; $display("FAIL ar_post_empty: got %b exp 1", empty); end
  endtask

  initial begin
    rst            = 1'b1;
    rx_data        = 8'h00;
    rx_data_valid  = 1'b0;
    rx_overrun     = 1'b0;
    rx_framing_err = 1'b0;
    rd_en          = 1'b0;
    clear_status   = 1'b0;

    test_reset();
    test_basic();
    test_fill_drain();
    test_back_to_back();
    test_timeout();
    test_overrun();
    test_async_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
